spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//   SPI target (slave) end of the on-board SPI link, for the peer that an SPI master drives.
//   sclk, cs and mosi are asynchronous pins; the block oversamples them with clk.
//   Supports all four CPOL/CPHA modes, MSB first, and back-to-back bytes within one cs frame.
//   Presents received bytes as a rx_valid pulse and takes transmit bytes through a
//   one-deep tx_load/tx_ready buffer.
// PARAMETERS
//   DATA_WIDTH   8   bits per word, shifted MSB first
//   SYNC_STAGES  2   flops in each input synchronizer (minimum 2)
// PORTS
//   clk         in   1           system clock; all logic on the rising edge
//   reset       in   1           asynchronous, active-high reset
//   cpol        in   1           sclk idle level
//   cpha        in   1           0: sample on the leading edge; 1: sample on the trailing edge
//   sclk        in   1           SPI clock from the master (asynchronous)
//   cs          in   1           chip select, active low (asynchronous)
//   mosi        in   1           serial data in (asynchronous)
//   miso        out  1           serial data out; 1'bz whenever the block is not selected
//   tx_data     in   DATA_WIDTH  next word to transmit
//   tx_load     in   1           write tx_data into the buffer; honoured only while tx_ready=1
//   tx_ready    out  1           transmit buffer empty
//   rx_data     out  DATA_WIDTH  last complete received word; held until the next one
//   rx_valid    out  1           1-cycle pulse: rx_data was updated
//   frame_err   out  1           1-cycle pulse: cs rose with a partial word
//   busy        out  1           high in SHIFT
// BEHAVIOUR
//   Reset values:
//     miso=1'bz, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE,
//     bit counter=0, buffer empty.
//   Synchronizers:
//     - sclk, cs and mosi each pass through SYNC_STAGES flops.
//     - The cs chain resets to 0, so a frame already in flight at reset release is ignored
//       until cs is seen high.
//     - Edge detection uses one further flop on synchronized sclk and cs.
//     - Pin-to-action latency is SYNC_STAGES+1 clk cycles.
//     - Requirement: f_sclk <= f_clk/8.
//   Edge definitions (using the latched mode):
//     - leading edge: sclk moves away from cpol
//     - trailing edge: sclk returns to cpol
//     - sample edge: leading when cpha=0, trailing when cpha=1
//     - shift edge: the other one
//   FSM states IDLE, SHIFT:
//     - IDLE -> SHIFT on a synchronized cs falling edge. On this transition:
//       * latch cpol/cpha; mode changes mid-frame are ignored
//       * load the tx shift register from the buffer (8'h00 if the buffer is empty)
//       * mark the buffer empty
//       * clear the bit counter
//     - SHIFT -> IDLE on a synchronized cs rising edge, in any cycle.
//   Transmit:
//     - cpha=0: the MSB drives miso in the first SHIFT cycle; the next bit goes out on each
//       shift edge.
//     - cpha=1: the MSB goes out on the first leading edge; the next bit goes out on each
//       later shift edge.
//   Receive:
//     - On each sample edge, synchronized mosi shifts into rx_shift LSB and the bit counter
//       increments.
//     - On the DATA_WIDTH-th sample edge, the cycle after the edge is detected:
//       * rx_data <= the assembled word and rx_valid=1 for one cycle
//       * the counter wraps to 0
//       * the tx shift register reloads from the buffer (8'h00 if empty), so the next word's
//         MSB follows without a gap
//   Transmit buffer:
//     - tx_load with tx_ready=1 writes the buffer; tx_ready drops the next cycle.
//     - tx_load with tx_ready=0 is ignored and the buffer is unchanged.
//     - tx_ready rises the cycle after the buffer is consumed by a load into the shift register.
//     - tx_load in the same cycle as consumption: the old contents go out, the new word is
//       stored, and tx_ready stays 0.
//   cs rising:
//     - with bit counter != 0: partial word discarded, rx_data unchanged, frame_err pulses once
//     - with bit counter = 0: no error
//     - either way, miso = 1'bz from the following cycle
//   Other boundaries:
//     - sclk edges while in IDLE are ignored.
//     - Reset mid-frame: all registers return to reset values immediately and the next frame
//       requires cs to go high and then low.
// TESTING
//   1. Mode 0, tx buffer=0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1;
//      rx_data=0x3C; one rx_valid pulse.
//   2. Modes 1, 2, 3, each with tx=0x81, master sends 0x7E -> rx_data=0x7E, master reads
//      0x81 in every mode.
//   3. One frame of two words, buffer reloaded with 0x55 after tx_ready rises -> rx_valid
//      twice, second MISO word 0x55.
//   4. Empty buffer, master sends 0xFF -> miso shifts 0x00, tx_ready stays 1, rx_data=0xFF.
//   5. cs raised after 5 bits -> frame_err 1-cycle pulse, no rx_valid, rx_data unchanged,
//      miso=Z.
//   6. reset asserted after bit 3, released while cs stays low -> no rx_valid until a new
//      cs high-to-low frame.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target with oversampled pins, all four CPOL/CPHA modes and back-to-back words per frame.
// A one-deep transmit buffer feeds the shift register at frame start and at every word boundary.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d;
    logic                   r_cpol, r_cpha;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_rx_shift, r_tx_shift, r_buf, r_rx_data;
    logic                   r_buf_full, r_skip_shift, r_rx_valid, r_frame_err;

    logic w_sclk, w_cs, w_mosi, w_sclk_edge, w_lead, w_trail;
    logic w_cs_fall, w_cs_rise, w_in_shift, w_sample, w_shift, w_start, w_word_done;
    logic w_consume, w_load_acc;
    logic [DATA_WIDTH-1:0] w_next_tx, w_rx_word;

    // cs chain resets low so a frame already running at reset release needs a fresh cs fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        w_sclk      = r_sclk_sync[SYNC_STAGES-1];
        w_cs        = r_cs_sync[SYNC_STAGES-1];
        w_mosi      = r_mosi_sync[SYNC_STAGES-1];
        w_cs_fall   = r_cs_d & ~w_cs;
        w_cs_rise   = ~r_cs_d & w_cs;
        w_sclk_edge = w_sclk ^ r_sclk_d;
        w_lead      = w_sclk_edge & (w_sclk != r_cpol);
        w_trail     = w_sclk_edge & (w_sclk == r_cpol);
        w_in_shift  = (r_state == SHIFT) & ~w_cs_rise;
        w_sample    = w_in_shift & (r_cpha ? w_trail : w_lead);
        w_shift     = w_in_shift & (r_cpha ? w_lead : w_trail);
        w_start     = (r_state == IDLE) & w_cs_fall;
        w_word_done = w_sample & (r_bit_cnt == LAST_BIT);
        w_consume   = w_start | w_word_done;
        // A load coinciding with consumption is kept: the old word leaves, the new one stays
        w_load_acc  = tx_load & (~r_buf_full | w_consume);
        w_next_tx   = r_buf_full ? r_buf : '0;
        w_rx_word   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_skip_shift <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid  <= w_word_done;
            r_frame_err <= (r_state == SHIFT) & w_cs_rise & (r_bit_cnt != '0);

            if (w_load_acc) begin
                r_buf <= tx_data;
            end
            if (w_consume) begin
                r_buf_full <= w_load_acc;
            end else if (w_load_acc) begin
                r_buf_full <= 1'b1;
            end

            if (w_start) begin
                r_cpol       <= cpol;
                r_cpha       <= cpha;
                r_bit_cnt    <= '0;
                r_tx_shift   <= w_next_tx;
                // cpha=1 holds the MSB through the first leading edge
                r_skip_shift <= cpha;
            end else if (w_sample) begin
                r_rx_shift <= w_rx_word;
                if (w_word_done) begin
                    r_bit_cnt    <= '0;
                    r_rx_data    <= w_rx_word;
                    r_tx_shift   <= w_next_tx;
                    // The next shift edge still belongs to the boundary; keep the new MSB
                    r_skip_shift <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end else if (w_shift) begin
                if (r_skip_shift) begin
                    r_skip_shift <= 1'b0;
                end else begin
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign busy      = (r_state == SHIFT);
    assign miso      = busy ? r_tx_shift[DATA_WIDTH-1] : 1'bz;
    assign tx_ready  = ~r_buf_full;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master, a table of single-word frames (fixed and random)
// checked against a word-level model, plus hand-written multi-word, abort and reset sequences.
module tb_spi_slave;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    wire        miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready, rx_valid, frame_err, busy;
    logic [7:0] rx_data;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int rxv_cnt = 0, ferr_cnt = 0, txr_low_cnt = 0;
    logic [7:0] rx_log[$];
    logic [15:0] got;

    // Counts high cycles, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_log.push_back(rx_data);
        end
        if (frame_err) ferr_cnt++;
        if (!tx_ready) txr_low_cnt++;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame_start(input bit pol, input bit pha);
        @(negedge clk);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        cs   = 1'b1;
        repeat (HALF) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Master side: MSB first, samples miso on its sample edge just before toggling sclk
    task automatic shift_bits(input bit pol, input bit pha, input logic [15:0] mo, input int n);
        logic [15:0] m;
        m = mo;
        if (!pha) begin
            mosi = m[15];
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            if (!pha) got = {got[14:0], miso};
            else mosi = m[15];
            sclk = ~pol;
            repeat (HALF) @(negedge clk);
            if (pha) got = {got[14:0], miso};
            sclk = pol;
            m = {m[14:0], 1'b0};
            if (!pha) mosi = m[15];
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic frame_end();
        @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    typedef struct {
        bit [1:0]   mode;
        bit         loaded;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rb, fb, tb, lb;
        logic [7:0] exp_last;

        vecs[0] = '{mode: 2'd0, loaded: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{mode: 2'd1, loaded: 1'b1, tx: 8'h81, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
        vecs[2] = '{mode: 2'd2, loaded: 1'b1, tx: 8'h81, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
        vecs[3] = '{mode: 2'd3, loaded: 1'b1, tx: 8'h81, mo: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
        vecs[4] = '{mode: 2'd0, loaded: 1'b0, tx: 8'h00, mo: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
        for (int i = 5; i < 13; i++) begin
            vecs[i].mode     = 2'($urandom_range(0, 3));
            vecs[i].loaded   = 1'($urandom_range(0, 1));
            vecs[i].tx       = 8'($urandom);
            vecs[i].mo       = 8'($urandom);
            // Word-level model: master reads the buffered word, or zeros when none was loaded
            vecs[i].exp_miso = vecs[i].loaded ? vecs[i].tx : 8'h00;
            vecs[i].exp_rx   = vecs[i].mo;
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].loaded) begin
                load_tx(vecs[i].tx);
                check($sformatf("v%0d_tx_ready_drop", i), tx_ready, 0);
            end
            rb = rxv_cnt; fb = ferr_cnt; tb = txr_low_cnt;
            got = '0;
            frame_start(vecs[i].mode[1], vecs[i].mode[0]);
            check($sformatf("v%0d_busy_in_frame", i), busy, 1);
            shift_bits(vecs[i].mode[1], vecs[i].mode[0], {vecs[i].mo, 8'h00}, 8);
            frame_end();
            check($sformatf("v%0d_miso_word", i), got[7:0], vecs[i].exp_miso);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_rx_valid_cnt", i), 16'(rxv_cnt - rb), 1);
            check($sformatf("v%0d_frame_err_cnt", i), 16'(ferr_cnt - fb), 0);
            check($sformatf("v%0d_tx_ready_end", i), tx_ready, 1);
            check($sformatf("v%0d_busy_end(miso_z)", i), busy, 0);
            if (!vecs[i].loaded)
                check($sformatf("v%0d_tx_ready_held", i), 16'(txr_low_cnt - tb), 0);
        end
        exp_last = vecs[12].exp_rx;

        // Two words in one frame, second word loaded once the first has been consumed
        load_tx(8'hC3);
        rb = rxv_cnt; lb = rx_log.size();
        got = '0;
        fork
            begin
                frame_start(1'b0, 1'b0);
                shift_bits(1'b0, 1'b0, 16'h1234, 16);
                frame_end();
            end
            begin
                for (int k = 0; k < 200 && !tx_ready; k++) @(negedge clk);
                check("t3_tx_ready_rise", tx_ready, 1);
                if (tx_ready) load_tx(8'h55);
            end
        join
        check("t3_miso_word0", got[15:8], 8'hC3);
        check("t3_miso_word1", got[7:0], 8'h55);
        check("t3_rx_valid_cnt", 16'(rxv_cnt - rb), 2);
        if (rx_log.size() >= lb + 2) begin
            check("t3_rx_word0", rx_log[lb], 8'h12);
            check("t3_rx_word1", rx_log[lb+1], 8'h34);
        end else begin
            check("t3_rx_log_size", 16'(rx_log.size() - lb), 2);
        end
        check("t3_tx_ready_end", tx_ready, 1);
        exp_last = 8'h34;

        // cs raised after five bits
        rb = rxv_cnt; fb = ferr_cnt;
        frame_start(1'b0, 1'b0);
        shift_bits(1'b0, 1'b0, 16'hB000, 5);
        frame_end();
        check("t5_frame_err_cnt", 16'(ferr_cnt - fb), 1);
        check("t5_rx_valid_cnt", 16'(rxv_cnt - rb), 0);
        check("t5_rx_data_held", rx_data, exp_last);
        check("t5_busy(miso_z)", busy, 0);

        // Reset after bit 3 with cs held low; the remainder of that frame must be ignored
        rb = rxv_cnt; fb = ferr_cnt;
        frame_start(1'b0, 1'b0);
        shift_bits(1'b0, 1'b0, 16'hE000, 3);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tx_ready", tx_ready, 1);
        shift_bits(1'b0, 1'b0, 16'hF800, 5);
        check("t6_busy_after_rst", busy, 0);
        frame_end();
        check("t6_rx_valid_cnt", 16'(rxv_cnt - rb), 0);
        check("t6_frame_err_cnt", 16'(ferr_cnt - fb), 0);
        rb = rxv_cnt;
        frame_start(1'b0, 1'b0);
        shift_bits(1'b0, 1'b0, 16'h9600, 8);
        frame_end();
        check("t6_new_frame_rx_valid", 16'(rxv_cnt - rb), 1);
        check("t6_new_frame_rx_data", rx_data, 8'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
